// File: rtl/bus85_bridge.sv
// ---------------------------------------------------------------------------
// bus85_bridge
// Bus-side interface stage sitting directly behind an 8085-compatible core.
//  - Demultiplexes the AD bus with ALE into a 16-bit latched address.
//  - Turns the RD/WR strobes into a single-request handshake towards the
//    backing store, stretching the core cycle by holding READY low.
//  - A 4-bit watchdog aborts a request that is never acknowledged and
//    raises a sticky error flag.
//  - Optional macro INTA_VEC_EN: answers INTA cycles locally with RSTVEC
//    without touching the backing store. When the macro is undefined,
//    INTA cycles are ignored entirely.
// ---------------------------------------------------------------------------
module bus85_bridge #(
    parameter int unsigned TIMEOUT = 15,
    parameter logic [7:0]  RSTVEC  = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ad_in,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    input  logic [7:0]  a_hi,
    input  logic        ale,
    input  logic        rd_,
    input  logic        wr_,
    input  logic        inta_,
    input  logic        iom_,
    output logic        ready,
    output logic [15:0] bus_addr,
    output logic        bus_io,
    output logic        bus_req,
    output logic        bus_we,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err,
    input  logic        err_clr
);

    // Watchdog limit folded into the counter width (valid range 1..15).
    localparam logic [3:0] L_TIMEOUT = 4'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA
    } state_t;

    // Which strobe started the current cycle; it decides which strobe ends it.
    typedef enum logic [1:0] {
        C_RD,
        C_WR,
        C_INTA
    } cyc_t;

    state_t      r_state;
    cyc_t        r_cyc;
    logic [3:0]  r_cnt;
    logic [7:0]  r_ad_out;
    logic        r_ad_oe;
    logic        r_ready;
    logic [15:0] r_bus_addr;
    logic        r_bus_io;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [7:0]  r_bus_wdata;
    logic        r_bus_err;

    logic        w_rd;
    logic        w_wr;
    logic        w_inta;
    logic        w_strobe_low;
    logic [3:0]  w_cnt_next;
    logic        w_timeout;
    logic        w_is_rd;

    assign w_rd       = ~rd_;
    assign w_wr       = ~wr_;
    assign w_inta     = ~inta_;
    assign w_is_rd    = (r_cyc == C_RD);
    assign w_cnt_next = r_cnt + 4'd1;
    // Counter reaching the limit on this edge means the request has been
    // outstanding for TIMEOUT full cycles.
    assign w_timeout  = (w_cnt_next == L_TIMEOUT);

    // Strobe belonging to the cycle in progress, active high.
    always_comb begin
        w_strobe_low = 1'b0;
        case (r_cyc)
            C_RD:    w_strobe_low = w_rd;
            C_WR:    w_strobe_low = w_wr;
            C_INTA:  w_strobe_low = w_inta;
            default: w_strobe_low = 1'b0;
        endcase
    end

    // Address latch, bus-cycle FSM, watchdog and sticky error, all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cyc       <= C_RD;
            r_cnt       <= 4'd0;
            r_ad_out    <= 8'h00;
            r_ad_oe     <= 1'b0;
            r_ready     <= 1'b1;
            r_bus_addr  <= 16'h0000;
            r_bus_io    <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_wdata <= 8'h00;
            r_bus_err   <= 1'b0;
        end else begin
            // The address is captured on every ALE edge, whatever the state.
            if (ale) begin
                r_bus_addr <= {a_hi, ad_in};
                r_bus_io   <= iom_;
            end

            // A timeout assignment further down overrides this clear.
            if (err_clr) begin
                r_bus_err <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rd) begin
                        // Read wins when both RD and WR are low.
                        r_state   <= S_REQ;
                        r_cyc     <= C_RD;
                        r_cnt     <= 4'd0;
                        r_bus_req <= 1'b1;
                        r_bus_we  <= 1'b0;
                        r_ready   <= 1'b0;
                    end else if (w_wr) begin
                        r_state     <= S_REQ;
                        r_cyc       <= C_WR;
                        r_cnt       <= 4'd0;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b1;
                        r_bus_wdata <= ad_in;
                        r_ready     <= 1'b0;
                    end
`ifdef INTA_VEC_EN
                    else if (w_inta) begin
                        // Local vector: no request, no wait states.
                        r_state  <= S_DATA;
                        r_cyc    <= C_INTA;
                        r_ad_out <= RSTVEC;
                        r_ad_oe  <= 1'b1;
                        r_ready  <= 1'b1;
                    end
`endif
                end

                S_REQ: begin
                    if (ale) begin
                        // New address phase: abandon the outstanding request.
                        r_state   <= S_IDLE;
                        r_cnt     <= 4'd0;
                        r_bus_req <= 1'b0;
                        r_ad_oe   <= 1'b0;
                        r_ready   <= 1'b1;
                    end else if (bus_ack) begin
                        if (w_is_rd) begin
                            r_ad_out <= bus_rdata;
                            r_ad_oe  <= w_rd;
                        end
                        r_state   <= S_DATA;
                        r_cnt     <= w_cnt_next;
                        r_bus_req <= 1'b0;
                        r_ready   <= 1'b1;
                    end else if (w_timeout) begin
                        // Stalled store: hand the core an all-ones byte.
                        if (w_is_rd) begin
                            r_ad_out <= 8'hFF;
                            r_ad_oe  <= w_rd;
                        end
                        r_state   <= S_DATA;
                        r_cnt     <= w_cnt_next;
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_ready   <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end

                S_DATA: begin
                    if (ale) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= 4'd0;
                        r_bus_req <= 1'b0;
                        r_ad_oe   <= 1'b0;
                        r_ready   <= 1'b1;
                    end else if (!w_strobe_low) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                        r_ad_oe <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= 4'd0;
                    r_bus_req <= 1'b0;
                    r_ad_oe   <= 1'b0;
                    r_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign ad_out    = r_ad_out;
    assign ad_oe     = r_ad_oe;
    assign ready     = r_ready;
    assign bus_addr  = r_bus_addr;
    assign bus_io    = r_bus_io;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_wdata = r_bus_wdata;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_bus85_bridge.sv
// ---------------------------------------------------------------------------
// tb_bus85_bridge
// Self-checking bench: directed bus cycles followed by randomized
// transactions, checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_bus85_bridge;

    localparam int TO = 15;

    logic        clk;
    logic        rst;
    logic [7:0]  ad_in;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic [7:0]  a_hi;
    logic        ale;
    logic        rd_;
    logic        wr_;
    logic        inta_;
    logic        iom_;
    logic        ready;
    logic [15:0] bus_addr;
    logic        bus_io;
    logic        bus_req;
    logic        bus_we;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ack;
    logic        bus_err;
    logic        err_clr;

    int total;
    int bad;

    // Reference model state
    logic [7:0] m_adout;
    logic       m_err;

    bus85_bridge #(.TIMEOUT(TO), .RSTVEC(8'hFF)) dut (
        .clk(clk), .rst(rst), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .a_hi(a_hi), .ale(ale), .rd_(rd_), .wr_(wr_), .inta_(inta_),
        .iom_(iom_), .ready(ready), .bus_addr(bus_addr), .bus_io(bus_io),
        .bus_req(bus_req), .bus_we(bus_we), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ale_phase(input logic [15:0] addr, input logic iom);
        ale   = 1'b1;
        a_hi  = addr[15:8];
        ad_in = addr[7:0];
        iom_  = iom;
        tick;
        ale = 1'b0;
        chk("addr_latch", bus_addr, addr);
        chk("io_latch", bus_io, iom);
    endtask

    // One complete bus cycle. ackd: cycle (1..TO) at which bus_ack is
    // sampled, 0 = never acknowledged. hold: extra cycles with strobe low.
    task automatic do_txn(input bit wr, input bit both, input bit iom,
                          input logic [15:0] addr, input logic [7:0] wd,
                          input logic [7:0] rdv, input int ackd, input int hold);
        bit is_rd;
        bit done;
        bit acked;
        bit ec;
        bit fin;
        int k;
        is_rd = !wr;
        ale_phase(addr, iom);
        ad_in = wr ? wd : 8'($urandom);
        if (wr) wr_ = 1'b0;
        else begin
            rd_ = 1'b0;
            if (both) wr_ = 1'b0;
        end
        tick;
        chk("req_start", bus_req, 1);
        chk("ready_start", ready, 0);
        chk("we", bus_we, wr);
        if (wr) chk("wdata", bus_wdata, wd);
        k = 0; done = 0; acked = 0;
        while (!done) begin
            k++;
            bus_ack   = (k == ackd);
            bus_rdata = rdv;
            ec        = ($urandom_range(0, 3) == 0);
            err_clr   = ec;
            tick;
            bus_ack = 1'b0;
            err_clr = 1'b0;
            fin = (k == ackd) || (k == TO);
            if (ec) m_err = 1'b0;
            if (k == ackd) acked = 1;
            else if (k == TO) m_err = 1'b1;
            chk("req_hold", bus_req, !fin);
            chk("ready_wait", ready, fin);
            if (fin) done = 1;
        end
        if (is_rd) m_adout = acked ? rdv : 8'hFF;
        chk("ad_out", ad_out, m_adout);
        chk("ad_oe_data", ad_oe, is_rd);
        chk("bus_err", bus_err, m_err);
        for (int h = 0; h < hold; h++) begin
            bus_ack   = $urandom_range(0, 1);
            bus_rdata = 8'($urandom);
            tick;
            bus_ack = 1'b0;
            chk("ad_oe_hold", ad_oe, is_rd);
            chk("ad_out_hold", ad_out, m_adout);
            chk("req_idle", bus_req, 0);
            chk("ready_hold", ready, 1);
        end
        rd_ = 1'b1;
        wr_ = 1'b1;
        tick;
        chk("ad_oe_end", ad_oe, 0);
        chk("ready_end", ready, 1);
    endtask

    task automatic clear_err;
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        m_err = 1'b0;
        chk("err_clr", bus_err, 0);
    endtask

    initial begin
        total = 0; bad = 0;
        m_adout = 8'h00; m_err = 1'b0;
        rst = 1'b1; ad_in = 8'h00; a_hi = 8'h00; ale = 1'b0;
        rd_ = 1'b1; wr_ = 1'b1; inta_ = 1'b1; iom_ = 1'b0;
        bus_rdata = 8'h00; bus_ack = 1'b0; err_clr = 1'b0;
        tick; tick;
        chk("rst_ad_out", ad_out, 8'h00);
        chk("rst_ad_oe", ad_oe, 0);
        chk("rst_ready", ready, 1);
        chk("rst_addr", bus_addr, 16'h0000);
        chk("rst_io", bus_io, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_wdata", bus_wdata, 8'h00);
        chk("rst_err", bus_err, 0);
        rst = 1'b0;
        tick;

        // Read 1234 acked after 3 cycles with 5A.
        do_txn(0, 0, 0, 16'h1234, 8'h00, 8'h5A, 3, 2);
        // IO write to 0080 with immediate ack.
        do_txn(1, 0, 1, 16'h0080, 8'hA5, 8'h00, 1, 1);
        // Read with no ack: watchdog fires.
        do_txn(0, 0, 0, 16'h4000, 8'h00, 8'h11, 0, 0);
        tick; tick;
        chk("err_sticky", bus_err, m_err);
        clear_err;

        // Interrupt acknowledge cycle.
        inta_ = 1'b0;
        tick;
`ifdef INTA_VEC_EN
        m_adout = 8'hFF;
        chk("inta_oe", ad_oe, 1);
        chk("inta_out", ad_out, 8'hFF);
`else
        chk("inta_oe", ad_oe, 0);
        chk("inta_out", ad_out, m_adout);
`endif
        chk("inta_ready", ready, 1);
        chk("inta_req", bus_req, 0);
        tick;
        chk("inta_req2", bus_req, 0);
        inta_ = 1'b1;
        tick;
        tick;
        chk("inta_oe_end", ad_oe, 0);

        // ALE during REQ aborts, late ack ignored.
        ale_phase(16'h1111, 0);
        rd_ = 1'b0;
        tick; tick;
        chk("abort_pre_req", bus_req, 1);
        ale = 1'b1; a_hi = 8'hBE; ad_in = 8'hEF; rd_ = 1'b1;
        tick;
        ale = 1'b0;
        chk("abort_req", bus_req, 0);
        chk("abort_ready", ready, 1);
        chk("abort_oe", ad_oe, 0);
        chk("abort_addr", bus_addr, 16'hBEEF);
        bus_ack = 1'b1; bus_rdata = 8'h77;
        tick;
        bus_ack = 1'b0;
        chk("late_ack_req", bus_req, 0);
        chk("late_ack_out", ad_out, m_adout);
        chk("late_ack_ready", ready, 1);

        // Asynchronous reset in the middle of a request.
        ale_phase(16'h2222, 1);
        rd_ = 1'b0;
        tick; tick;
        rst = 1'b1;
        #1;
        chk("mrst_req", bus_req, 0);
        chk("mrst_ready", ready, 1);
        chk("mrst_addr", bus_addr, 16'h0000);
        chk("mrst_io", bus_io, 0);
        chk("mrst_out", ad_out, 8'h00);
        m_adout = 8'h00; m_err = 1'b0;
        rd_ = 1'b1;
        tick;
        rst = 1'b0;
        bus_ack = 1'b1; bus_rdata = 8'h99;
        tick;
        bus_ack = 1'b0;
        chk("mrst_late_req", bus_req, 0);
        chk("mrst_late_out", ad_out, 8'h00);
        chk("mrst_late_oe", ad_oe, 0);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            bit wr;
            int ackd;
            wr = $urandom_range(0, 1);
            ackd = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
            do_txn(wr, !wr && ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                   16'($urandom), 8'($urandom), 8'($urandom), ackd,
                   $urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) clear_err;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
